load_store_ctrl: RTL and testbench

- Multi-cycle sequencer for all data-memory accesses of the MIPS core: lw/lh/lb and sw/sh/sb.
- Issues the word-aligned memory address and waits the fixed memory latency.
- Loads: shifts the addressed lane into bits [7:0]/[15:0] and writes the MDR. Drives the load-extension unit's 2-bit size control.
- Sub-word stores: performs read-modify-write. Sits between the main control FSM and the data memory/MDR.

---
 rtl/load_store_ctrl_pkg.sv | 35 +++
 rtl/load_store_ctrl_store_merge.sv | 35 +++
 rtl/load_store_ctrl.sv | 176 +++++++++++++++++
 tb/tb_load_store_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// load_store_pkg
// Shared types and helpers for the data-memory load/store sequencer.
//   state_e          : sequencer states
//   SZ_WORD/HALF/BYTE: access size encodings (2'b11 is treated as a word)
//   is_misaligned()  : natural-alignment check for a request
// -----------------------------------------------------------------------------
package load_store_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_CAPTURE,
    S_WRITE,
    S_EXC
  } state_e;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Words (and the 2'b11 alias) need both offset bits clear, halves need
  // bit 0 clear, bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_HALF: bad = offset[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = (offset != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_ctrl_store_merge.sv
// -----------------------------------------------------------------------------
// store_merge
// Combinational lane merge for sub-word stores (little-endian lanes).
// Ports:
//   old_word in  32  word read back from memory
//   wdata    in  32  store data; low half/byte used for sub-word sizes
//   size     in  2   access size (SZ_WORD / SZ_HALF / SZ_BYTE, 11 = word)
//   offset   in  2   byte offset addr[1:0]
//   new_word out 32  word to write back
// -----------------------------------------------------------------------------
module store_merge
  import load_store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] new_word
);

  // NOTE: every output of a combinational block gets a default before the
  // case, otherwise an uncovered branch infers a latch.
  always_comb begin
    new_word = old_word;
    case (size)
      SZ_HALF: begin
        if (offset[1]) new_word[31:16] = wdata[15:0];
        else           new_word[15:0]  = wdata[15:0];
      end
      SZ_BYTE: new_word[{offset, 3'b000} +: 8] = wdata[7:0];
      default: new_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_ctrl.sv
// -----------------------------------------------------------------------------
// load_store_ctrl
// Multi-cycle sequencer for lw/lh/lb and sw/sh/sb. Issues a word-aligned
// address, waits MEM_LATENCY cycles, then captures load data into the MDR or
// writes (read-modify-write for sub-word stores) back to memory.
//
// Optional feature: define LOAD_SIGN_EXT_EN to add the load_signed input; a
// signed half/byte load is then sign-extended here and load_ctrl forced to 00.
//
// Ports:
//   clk         in  1   system clock
//   reset       in  1   synchronous, active-low reset
//   start       in  1   request pulse, accepted only in IDLE
//   is_store    in  1   1 = store, 0 = load
//   size        in  2   00 word, 01 half, 10 byte, 11 word
//   addr        in  32  byte address
//   wdata       in  32  store data
//   load_signed in  1   (LOAD_SIGN_EXT_EN only) signed sub-word load
//   mem_rdata   in  32  data memory read word
//   mem_addr    out 32  word-aligned address
//   mem_wdata   out 32  data to memory (valid while mem_wr)
//   mem_wr      out 1   memory write strobe
//   mdr_data    out 32  lane-shifted read word (valid while mdr_we)
//   mdr_we      out 1   MDR load enable
//   load_ctrl   out 2   size control to load-extension unit (held)
//   busy        out 1   not IDLE
//   done        out 1   completion pulse
//   misaligned  out 1   alignment-exception pulse
// -----------------------------------------------------------------------------
module load_store_ctrl
  import load_store_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef LOAD_SIGN_EXT_EN
  input  logic        load_signed,
`endif
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic [31:0] mdr_data,
  output logic        mdr_we,
  output logic [1:0]  load_ctrl,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  // Wide enough to hold MEM_LATENCY-1.
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

  state_e        state_q, state_d;
  logic [31:0]   addr_q, wdata_q, hold_q, merged, shifted;
  logic [1:0]    size_q, load_ctrl_q, cap_ctrl, size_norm;
  logic          store_q;
  logic [CW-1:0] cnt_q;
`ifdef LOAD_SIGN_EXT_EN
  logic          signed_q;
`endif

  assign size_norm = (size == 2'b11) ? SZ_WORD : size;
  assign mem_addr  = {addr_q[31:2], 2'b00};

  store_merge u_store_merge (
    .old_word (hold_q),
    .wdata    (wdata_q),
    .size     (size_q),
    .offset   (addr_q[1:0]),
    .new_word (merged)
  );

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SZ_WORD;
      store_q     <= 1'b0;
      cnt_q       <= '0;
      hold_q      <= '0;
      load_ctrl_q <= 2'b00;
`ifdef LOAD_SIGN_EXT_EN
      signed_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        addr_q   <= addr;
        wdata_q  <= wdata;
        size_q   <= size_norm;
        store_q  <= is_store;
`ifdef LOAD_SIGN_EXT_EN
        signed_q <= load_signed;
`endif
      end
      // Counter is loaded on entry to RD_WAIT and counts down to zero there.
      if (state_q != S_RD_WAIT && state_d == S_RD_WAIT)
        cnt_q <= CNT_INIT;
      else if (state_q == S_RD_WAIT && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
      // Old word for the read-modify-write merge, taken as RD_WAIT ends.
      if (state_q == S_RD_WAIT && cnt_q == '0)
        hold_q <= mem_rdata;
      if (state_q == S_CAPTURE)
        load_ctrl_q <= cap_ctrl;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_wdata  = '0;
    mem_wr     = 1'b0;
    mdr_data   = '0;
    mdr_we     = 1'b0;
    load_ctrl  = load_ctrl_q;
    cap_ctrl   = size_q;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    misaligned = 1'b0;
    shifted    = mem_rdata >> {addr_q[1:0], 3'b000};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_misaligned(size_norm, addr[1:0])) state_d = S_EXC;
          else if (!is_store)                      state_d = S_RD_WAIT;
          else if (size_norm == SZ_WORD)           state_d = S_WRITE;
          else                                     state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) state_d = store_q ? S_WRITE : S_CAPTURE;
      end
      S_CAPTURE: begin
        mdr_we   = 1'b1;
        done     = 1'b1;
        mdr_data = shifted;
`ifdef LOAD_SIGN_EXT_EN
        // Sign-extend here and tell the extension unit to pass through.
        if (signed_q && size_q == SZ_HALF) begin
          mdr_data = {{16{shifted[15]}}, shifted[15:0]};
          cap_ctrl = SZ_WORD;
        end else if (signed_q && size_q == SZ_BYTE) begin
          mdr_data = {{24{shifted[7]}}, shifted[7:0]};
          cap_ctrl = SZ_WORD;
        end
`endif
        load_ctrl = cap_ctrl;
        state_d   = S_IDLE;
      end
      S_WRITE: begin
        mem_wr    = 1'b1;
        mem_wdata = merged;
        done      = 1'b1;
        state_d   = S_IDLE;
      end
      S_EXC: begin
        misaligned = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_ctrl.sv
// -----------------------------------------------------------------------------
// tb_load_store_ctrl
// Directed bench for load_store_ctrl. Two instances: u_dut1 (MEM_LATENCY=1)
// and u_dut3 (MEM_LATENCY=3), sharing request inputs but with separate start.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_load_store_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
`ifdef LOAD_SIGN_EXT_EN
  logic        load_signed = 1'b0;
`endif

  logic [31:0] mem_addr1, mem_wdata1, mdr_data1;
  logic        mem_wr1, mdr_we1, busy1, done1, misaligned1;
  logic [1:0]  load_ctrl1;
  logic [31:0] mem_addr3, mem_wdata3, mdr_data3;
  logic        mem_wr3, mdr_we3, busy3, done3, misaligned3;
  logic [1:0]  load_ctrl3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_ctrl #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .is_store(is_store),
    .size(size), .addr(addr), .wdata(wdata),
`ifdef LOAD_SIGN_EXT_EN
    .load_signed(load_signed),
`endif
    .mem_rdata(mem_rdata), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_wr(mem_wr1), .mdr_data(mdr_data1), .mdr_we(mdr_we1),
    .load_ctrl(load_ctrl1), .busy(busy1), .done(done1),
    .misaligned(misaligned1)
  );

  load_store_ctrl #(.MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .is_store(is_store),
    .size(size), .addr(addr), .wdata(wdata),
`ifdef LOAD_SIGN_EXT_EN
    .load_signed(load_signed),
`endif
    .mem_rdata(mem_rdata), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_wr(mem_wr3), .mdr_data(mdr_data3), .mdr_we(mdr_we3),
    .load_ctrl(load_ctrl3), .busy(busy3), .done(done3),
    .misaligned(misaligned3)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic st, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd);
    is_store  = st;
    size      = sz;
    addr      = a;
    wdata     = wd;
    mem_rdata = rd;
  endtask

  // Hard stop if something hangs despite the bounded loops below.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  first_done, n_done, n_wr, waited;
    logic saw_wr, saw_done;

    // ---------------- reset ----------------
    reset = 1'b0;
    tick(); tick();
    check("rst_busy",      32'(busy1),       32'h0);
    check("rst_done",      32'(done1),       32'h0);
    check("rst_mem_wr",    32'(mem_wr1),     32'h0);
    check("rst_mdr_we",    32'(mdr_we1),     32'h0);
    check("rst_misalign",  32'(misaligned1), 32'h0);
    check("rst_load_ctrl", 32'(load_ctrl1),  32'h0);
    check("rst_mem_addr",  mem_addr1,        32'h0);
    check("rst_mdr_data",  mdr_data1,        32'h0);
    check("rst_busy3",     32'(busy3),       32'h0);
    reset = 1'b1;
    tick();

    // ---------------- lb, latency 1 ----------------
    req(1'b0, 2'b10, 32'h0000_0013, 32'h0, 32'hAABB_CCDD);
    start1 = 1'b1;
    tick(); start1 = 1'b0;                        // cycle 1: RD_WAIT
    check("lb_c1_addr",   mem_addr1,      32'h0000_0010);
    check("lb_c1_busy",   32'(busy1),     32'h1);
    check("lb_c1_done",   32'(done1),     32'h0);
    check("lb_c1_mdr_we", 32'(mdr_we1),   32'h0);
    tick();                                       // cycle 2: CAPTURE
    check("lb_c2_mdr_we", 32'(mdr_we1),   32'h1);
    check("lb_c2_mdr",    mdr_data1,      32'h0000_00AA);
    check("lb_c2_ctrl",   32'(load_ctrl1), 32'h2);
    check("lb_c2_done",   32'(done1),     32'h1);
    check("lb_c2_wr",     32'(mem_wr1),   32'h0);
    tick();                                       // cycle 3: IDLE
    check("lb_c3_busy",   32'(busy1),     32'h0);
    check("lb_c3_done",   32'(done1),     32'h0);
    check("lb_c3_ctrl_hold", 32'(load_ctrl1), 32'h2);

    // ---------------- lh unsigned at 0x02 ----------------
    req(1'b0, 2'b01, 32'h0000_0002, 32'h0, 32'h8001_0000);
    start1 = 1'b1;
    tick(); start1 = 1'b0;
    check("lh_c1_misalign", 32'(misaligned1), 32'h0);
    tick();
    check("lh_c2_mdr",  mdr_data1,       32'h0000_8001);
    check("lh_c2_ctrl", 32'(load_ctrl1), 32'h1);
    tick();

    // ---------------- sh, read-modify-write ----------------
    req(1'b1, 2'b01, 32'h0000_0022, 32'h0000_1234, 32'h5566_7788);
    start1 = 1'b1;
    tick(); start1 = 1'b0;                        // cycle 1: RD_WAIT
    check("sh_c1_addr", mem_addr1,     32'h0000_0020);
    check("sh_c1_wr",   32'(mem_wr1),  32'h0);
    tick();                                       // cycle 2: WRITE
    check("sh_c2_wr",    32'(mem_wr1), 32'h1);
    check("sh_c2_wdata", mem_wdata1,   32'h1234_7788);
    check("sh_c2_done",  32'(done1),   32'h1);
    tick();
    check("sh_c3_wr",    32'(mem_wr1), 32'h0);
    check("sh_c3_busy",  32'(busy1),   32'h0);

    // ---------------- sb, lane 1 ----------------
    req(1'b1, 2'b10, 32'h0000_0101, 32'hFFFF_FFAB, 32'h5566_7788);
    start1 = 1'b1;
    tick(); start1 = 1'b0;
    tick();
    check("sb_c2_wr",    32'(mem_wr1), 32'h1);
    check("sb_c2_wdata", mem_wdata1,   32'h5566_AB88);
    check("sb_c2_addr",  mem_addr1,    32'h0000_0100);
    tick();

    // ---------------- sw, done at cycle 1 ----------------
    req(1'b1, 2'b00, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1111_1111);
    start1 = 1'b1;
    tick(); start1 = 1'b0;
    check("sw_c1_wr",    32'(mem_wr1), 32'h1);
    check("sw_c1_wdata", mem_wdata1,   32'hDEAD_BEEF);
    check("sw_c1_done",  32'(done1),   32'h1);
    check("sw_c1_addr",  mem_addr1,    32'h0000_0040);
    tick();
    check("sw_c2_busy",  32'(busy1),   32'h0);

    // ---------------- misaligned lw at 0x05 ----------------
    req(1'b0, 2'b00, 32'h0000_0005, 32'h0, 32'h0);
    start1 = 1'b1;
    tick(); start1 = 1'b0;
    check("mis_c1_flag", 32'(misaligned1), 32'h1);
    check("mis_c1_wr",   32'(mem_wr1),     32'h0);
    check("mis_c1_done", 32'(done1),       32'h0);
    tick();
    check("mis_c2_flag", 32'(misaligned1), 32'h0);
    check("mis_c2_busy", 32'(busy1),       32'h0);
    check("mis_c2_done", 32'(done1),       32'h0);

    // ---------------- misaligned sh at 0x03 ----------------
    req(1'b1, 2'b01, 32'h0000_0003, 32'h0, 32'h0);
    start1 = 1'b1;
    tick(); start1 = 1'b0;
    check("mish_c1_flag", 32'(misaligned1), 32'h1);
    check("mish_c1_wr",   32'(mem_wr1),     32'h0);
    tick();

    // ---------------- size 11 treated as word: misaligned at 0x06 -------
    req(1'b0, 2'b11, 32'h0000_0006, 32'h0, 32'h0);
    start1 = 1'b1;
    tick(); start1 = 1'b0;
    check("sz11_c1_flag", 32'(misaligned1), 32'h1);
    tick();

    // ---------------- lw latency 3, start held high ----------------
    req(1'b0, 2'b00, 32'h0000_0008, 32'h0, 32'h1234_5678);
    start3 = 1'b1;
    first_done = -1; n_done = 0; n_wr = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (done3) begin
        n_done++;
        if (first_done < 0) first_done = c;
        check("l3_mdr", mdr_data3, 32'h1234_5678);
      end
      if (mem_wr3) n_wr++;
    end
    check("l3_first_done", 32'(first_done), 32'd4);
    check("l3_n_done",     32'(n_done),     32'd1);
    check("l3_n_wr",       32'(n_wr),       32'd0);
    check("l3_c5_busy",    32'(busy3),      32'h0);
    tick();                                       // cycle 6: re-accepted
    check("l3_c6_busy",    32'(busy3),      32'h1);
    start3 = 1'b0;
    waited = 0;
    while (busy3 && waited < 10) begin
      tick();
      waited++;
    end
    check("l3_drain_timeout", 32'(busy3), 32'h0);

    // ---------------- reset during RD_WAIT of sb ----------------
    req(1'b1, 2'b10, 32'h0000_0107, 32'h0000_00FF, 32'h0);
    start3 = 1'b1;
    tick(); start3 = 1'b0;                        // cycle 1: RD_WAIT
    check("rstw_c1_busy", 32'(busy3),  32'h1);
    check("rstw_c1_addr", mem_addr3,   32'h0000_0104);
    reset = 1'b0;
    tick();
    check("rstw_busy", 32'(busy3),      32'h0);
    check("rstw_wr",   32'(mem_wr3),    32'h0);
    check("rstw_done", 32'(done3),      32'h0);
    check("rstw_addr", mem_addr3,       32'h0);
    check("rstw_ctrl", 32'(load_ctrl3), 32'h0);
    reset = 1'b1;
    saw_wr = 1'b0; saw_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      saw_wr   |= mem_wr3;
      saw_done |= done3;
    end
    check("rstw_no_wr",   32'(saw_wr),   32'h0);
    check("rstw_no_done", 32'(saw_done), 32'h0);

`ifdef LOAD_SIGN_EXT_EN
    // ---------------- signed lh / lb ----------------
    req(1'b0, 2'b01, 32'h0000_0002, 32'h0, 32'h8001_0000);
    load_signed = 1'b1;
    start1 = 1'b1;
    tick(); start1 = 1'b0;
    tick();
    check("slh_mdr",  mdr_data1,       32'hFFFF_8001);
    check("slh_ctrl", 32'(load_ctrl1), 32'h0);
    tick();
    req(1'b0, 2'b10, 32'h0000_0001, 32'h0, 32'h0000_7F00);
    start1 = 1'b1;
    tick(); start1 = 1'b0;
    tick();
    check("slb_pos_mdr", mdr_data1, 32'h0000_007F);
    load_signed = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
